// File: rtl/mac_sequencer.sv
// mac_sequencer: walks a 3x3 convolution window over a feature map in raster
// order. It accepts windows from the line buffer, steps the output-map position
// counters, and tracks each accepted window through a MAC_LAT-deep
// valid/position/last pipeline so that the MAC result leaves tagged with its
// output position. MAC_LAT must be at least 2.
module mac_sequencer #(
    parameter int WID_DIM = 10,
    parameter int MAC_LAT = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [WID_DIM-1:0] cfg_rows,
    input  logic [WID_DIM-1:0] cfg_cols,
    input  logic               win_valid,
    output logic               win_ready,
    output logic               mac_enable,
    output logic               out_valid,
    output logic [WID_DIM-1:0] out_row,
    output logic [WID_DIM-1:0] out_col,
    output logic               out_last,
    output logic               busy,
    output logic               done,
    output logic               cfg_err
);

    // The 3x3 kernel needs at least three input rows and columns.
    localparam logic [WID_DIM-1:0] MIN_DIM = WID_DIM'(3);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [WID_DIM-1:0] rows_q, rows_d;
    logic [WID_DIM-1:0] cols_q, cols_d;
    logic [WID_DIM-1:0] pos_row_q, pos_row_d;
    logic [WID_DIM-1:0] pos_col_q, pos_col_d;
    logic               cfg_err_q, cfg_err_d;

    // Per-stage pipeline registers; stage MAC_LAT-1 lines up with the MAC output.
    logic               stg_vld_q  [MAC_LAT];
    logic               stg_vld_d  [MAC_LAT];
    logic               stg_last_q [MAC_LAT];
    logic               stg_last_d [MAC_LAT];
    logic [WID_DIM-1:0] stg_row_q  [MAC_LAT];
    logic [WID_DIM-1:0] stg_row_d  [MAC_LAT];
    logic [WID_DIM-1:0] stg_col_q  [MAC_LAT];
    logic [WID_DIM-1:0] stg_col_d  [MAC_LAT];

    logic accept;
    logic kill;
    logic at_last_col;
    logic at_last_pos;
    logic cfg_bad;

    assign accept      = win_valid && (state_q == S_RUN);
    // Abort only matters while a pass is in flight; it flushes the pipeline.
    assign kill        = abort && ((state_q == S_RUN) || (state_q == S_DRAIN));
    assign at_last_col = (pos_col_q == (cols_q - MIN_DIM));
    assign at_last_pos = at_last_col && (pos_row_q == (rows_q - MIN_DIM));
    assign cfg_bad     = (cfg_rows < MIN_DIM) || (cfg_cols < MIN_DIM);

    assign win_ready  = (state_q == S_RUN);
    assign busy       = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done       = (state_q == S_DONE);
    assign cfg_err    = cfg_err_q;
    assign mac_enable = stg_vld_q[MAC_LAT-2];
    assign out_valid  = stg_vld_q[MAC_LAT-1];
    assign out_last   = stg_vld_q[MAC_LAT-1] && stg_last_q[MAC_LAT-1];
    assign out_row    = stg_row_q[MAC_LAT-1];
    assign out_col    = stg_col_q[MAC_LAT-1];

    // Next-state, config latch and raster position counters.
    always_comb begin
        state_d   = state_q;
        rows_d    = rows_q;
        cols_d    = cols_q;
        pos_row_d = pos_row_q;
        pos_col_d = pos_col_q;
        cfg_err_d = cfg_err_q;
        case (state_q)
            S_IDLE: begin
                // Start beats a simultaneous abort here since abort is ignored in IDLE.
                if (start) begin
                    if (cfg_bad) begin
                        cfg_err_d = 1'b1;
                        state_d   = S_DONE;
                    end else begin
                        cfg_err_d = 1'b0;
                        rows_d    = cfg_rows;
                        cols_d    = cfg_cols;
                        pos_row_d = '0;
                        pos_col_d = '0;
                        state_d   = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (kill) begin
                    state_d = S_DONE;
                end else if (accept) begin
                    if (at_last_col) begin
                        pos_col_d = '0;
                        pos_row_d = pos_row_q + 1'b1;
                    end else begin
                        pos_col_d = pos_col_q + 1'b1;
                    end
                    if (at_last_pos) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (kill || out_last) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            rows_q    <= '0;
            cols_q    <= '0;
            pos_row_q <= '0;
            pos_col_q <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rows_q    <= rows_d;
            cols_q    <= cols_d;
            pos_row_q <= pos_row_d;
            pos_col_q <= pos_col_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < MAC_LAT; gi++) begin : g_stage
            // Stage gi takes the accepted window (stage 0) or the previous stage;
            // valid bits are cleared on abort so nothing in flight surfaces.
            always_comb begin
                if (gi == 0) begin
                    stg_vld_d[gi]  = accept && !kill;
                    stg_last_d[gi] = at_last_pos;
                    stg_row_d[gi]  = pos_row_q;
                    stg_col_d[gi]  = pos_col_q;
                end else begin
                    stg_vld_d[gi]  = stg_vld_q[(gi > 0) ? gi - 1 : 0] && !kill;
                    stg_last_d[gi] = stg_last_q[(gi > 0) ? gi - 1 : 0];
                    stg_row_d[gi]  = stg_row_q[(gi > 0) ? gi - 1 : 0];
                    stg_col_d[gi]  = stg_col_q[(gi > 0) ? gi - 1 : 0];
                end
            end

            // Pipeline stage register, shifts every cycle.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    stg_vld_q[gi]  <= 1'b0;
                    stg_last_q[gi] <= 1'b0;
                    stg_row_q[gi]  <= '0;
                    stg_col_q[gi]  <= '0;
                end else begin
                    stg_vld_q[gi]  <= stg_vld_d[gi];
                    stg_last_q[gi] <= stg_last_d[gi];
                    stg_row_q[gi]  <= stg_row_d[gi];
                    stg_col_q[gi]  <= stg_col_d[gi];
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_mac_sequencer.sv
// Self-checking bench for mac_sequencer. A reference model computes, cycle by
// cycle from the start pulse, what every output should be, using the pass
// geometry (output index n -> row n/(cols-2), col n%(cols-2)) and fixed
// latencies from window acceptance.
module tb_mac_sequencer;
    localparam int W    = 10;
    localparam int L    = 3;
    localparam int MAXC = 512;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         abort;
    logic [W-1:0] cfg_rows;
    logic [W-1:0] cfg_cols;
    logic         win_valid;
    logic         win_ready;
    logic         mac_enable;
    logic         out_valid;
    logic [W-1:0] out_row;
    logic [W-1:0] out_col;
    logic         out_last;
    logic         busy;
    logic         done;
    logic         cfg_err;

    mac_sequencer #(.WID_DIM(W), .MAC_LAT(L)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .cfg_rows   (cfg_rows),
        .cfg_cols   (cfg_cols),
        .win_valid  (win_valid),
        .win_ready  (win_ready),
        .mac_enable (mac_enable),
        .out_valid  (out_valid),
        .out_row    (out_row),
        .out_col    (out_col),
        .out_last   (out_last),
        .busy       (busy),
        .done       (done),
        .cfg_err    (cfg_err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Stimulus per cycle (cycle 0 = the cycle start is driven)
    bit vld_in   [MAXC];
    bit abort_in [MAXC];
    bit start_nz [MAXC];

    // Expected per-cycle outputs
    bit e_rdy [MAXC];
    bit e_men [MAXC];
    bit e_vld [MAXC];
    bit e_last[MAXC];
    bit e_busy[MAXC];
    bit e_done[MAXC];
    bit e_err [MAXC];
    int e_row [MAXC];
    int e_col [MAXC];

    // Packed word {ready, men, valid, last, busy, done, err, row[9:0], col[9:0]}
    logic [26:0] exp_w [MAXC];
    logic [26:0] obs_w [MAXC];

    int ncyc;
    int done_cyc;
    int abort_cyc;
    int exp_n_out;
    bit model_err = 1'b0;

    function automatic logic [26:0] pack(input logic rdy, input logic men, input logic vl,
                                         input logic lst, input logic bsy, input logic dn,
                                         input logic er, input logic [9:0] r, input logic [9:0] c);
        return {rdy, men, vl, lst, bsy, dn, er, r, c};
    endfunction

    function automatic logic [26:0] cmp_mask(input int c);
        return e_vld[c] ? 27'h7ffffff : 27'h7f00000;
    endfunction

    function automatic int count_obs_valid(input int n);
        int k = 0;
        for (int c = 0; c < n; c++) if (obs_w[c][24]) k++;
        return k;
    endfunction

    // mode 0: always valid, 1: valid on odd cycles, 2: random (75%)
    task automatic fill_stim(input int mode, input bit noise);
        for (int c = 0; c < MAXC; c++) begin
            case (mode)
                0:       vld_in[c] = 1'b1;
                1:       vld_in[c] = (c % 2) == 1;
                default: vld_in[c] = ($urandom % 4) != 0;
            endcase
            abort_in[c] = 1'b0;
            start_nz[c] = noise && (($urandom % 3) == 0);
        end
    endtask

    // Reference model of one pass; abort_after = number of acceptances after
    // which abort is raised (-1: never).
    task automatic build_model(input int r, input int cl, input int abort_after);
        int n_tot;
        int n;
        int t;
        int tl;
        for (int c = 0; c < MAXC; c++) begin
            e_rdy[c] = 0; e_men[c] = 0; e_vld[c] = 0; e_last[c] = 0;
            e_busy[c] = 0; e_done[c] = 0; e_row[c] = 0; e_col[c] = 0;
            e_err[c] = model_err;
        end
        abort_cyc = -1;
        if (r < 3 || cl < 3) begin
            done_cyc  = 1;
            model_err = 1'b1;
        end else begin
            n_tot = (r - 2) * (cl - 2);
            n = 0; t = 1; tl = 0;
            while (n < n_tot && t < MAXC - 16) begin
                e_rdy[t] = 1;
                if (abort_after >= 0 && n == abort_after) begin
                    abort_cyc = t;
                    break;
                end
                if (vld_in[t]) begin
                    e_men[t + L - 1] = 1;
                    e_vld[t + L]     = 1;
                    e_row[t + L]     = n / (cl - 2);
                    e_col[t + L]     = n % (cl - 2);
                    e_last[t + L]    = (n == n_tot - 1);
                    n++;
                    tl = t;
                end
                t++;
            end
            if (abort_cyc >= 0) begin
                done_cyc = abort_cyc + 1;
                for (int c = abort_cyc + 1; c < MAXC; c++) begin
                    e_men[c] = 0; e_vld[c] = 0; e_last[c] = 0;
                end
                abort_in[abort_cyc] = 1'b1;
            end else begin
                done_cyc = tl + L + 1;
            end
            for (int c = 1; c < done_cyc; c++) e_busy[c] = 1;
            model_err = 1'b0;
        end
        for (int c = 1; c < MAXC; c++) e_err[c] = model_err;
        e_done[done_cyc] = 1;
        ncyc = done_cyc + 2;
        exp_n_out = 0;
        for (int c = 0; c < MAXC; c++) begin
            if (c < 1 || c >= done_cyc) start_nz[c] = 1'b0;
            if (e_vld[c]) exp_n_out++;
            exp_w[c] = pack(e_rdy[c], e_men[c], e_vld[c], e_last[c], e_busy[c], e_done[c],
                            e_err[c], 10'(e_row[c]), 10'(e_col[c]));
        end
    endtask

    // Drive one pass and record outputs at each falling edge; stop_at >= 0
    // ends early after that cycle (leaving the pass in flight).
    task automatic drive_pass(input int r, input int cl, input bit abort_with_start, input int stop_at);
        int last_c;
        last_c = (stop_at >= 0) ? stop_at : ncyc - 1;
        for (int c = 0; c <= last_c; c++) begin
            @(posedge clk);
            #1;
            if (c == 0) begin
                start    = 1'b1;
                cfg_rows = W'(r);
                cfg_cols = W'(cl);
                abort    = abort_with_start;
            end else begin
                start    = start_nz[c];
                cfg_rows = W'($urandom_range(0, 9));
                cfg_cols = W'($urandom_range(0, 9));
                abort    = abort_in[c];
            end
            win_valid = vld_in[c];
            @(negedge clk);
            obs_w[c] = pack(win_ready, mac_enable, out_valid, out_last, busy, done, cfg_err,
                            out_row, out_col);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 0; abort = 0; win_valid = 0; cfg_rows = 0; cfg_cols = 0;
        #3;
        checks++;
        if (pack(win_ready, mac_enable, out_valid, out_last, busy, done, cfg_err, out_row, out_col) !== 27'h0) begin
            failures++;
            $display("FAIL reset_state got=%h exp=0", pack(win_ready, mac_enable, out_valid, out_last,
                     busy, done, cfg_err, out_row, out_col));
        end
        @(posedge clk); @(posedge clk); #2;
        rst = 1'b0;
        $display("reset released at %0t", $time);
    endtask

    task automatic test_full_pass();
        fill_stim(0, 0);
        build_model(5, 6, -1);
        drive_pass(5, 6, 0, -1);
        for (int c = 0; c < ncyc; c++) begin
            checks++;
            if ((obs_w[c] & cmp_mask(c)) !== (exp_w[c] & cmp_mask(c))) begin
                failures++;
                $display("FAIL full_pass cyc=%0d got=%h exp=%h", c, obs_w[c] & cmp_mask(c), exp_w[c] & cmp_mask(c));
            end
        end
        checks++;
        if (count_obs_valid(ncyc) !== 12) begin
            failures++;
            $display("FAIL full_pass_count got=%0d exp=12", count_obs_valid(ncyc));
        end
        // accepts in cycles 1..12: first output at 4, last (2,3) at 15, done at 16
        checks++;
        if (obs_w[4][24] !== 1'b1 || obs_w[3][24] !== 1'b0) begin
            failures++;
            $display("FAIL full_pass_first got=%b%b exp=01", obs_w[3][24], obs_w[4][24]);
        end
        checks++;
        if (obs_w[15][24:23] !== 2'b11 || obs_w[15][19:0] !== {10'd2, 10'd3} || obs_w[16][21] !== 1'b1) begin
            failures++;
            $display("FAIL full_pass_last got=%h exp=last(2,3)+done", {obs_w[15], obs_w[16][21]});
        end
        $display("pass full rows=5 cols=6 outputs=%0d cycles=%0d", count_obs_valid(ncyc), ncyc);
    endtask

    task automatic test_single();
        fill_stim(0, 0);
        build_model(3, 3, -1);
        drive_pass(3, 3, 0, -1);
        for (int c = 0; c < ncyc; c++) begin
            checks++;
            if ((obs_w[c] & cmp_mask(c)) !== (exp_w[c] & cmp_mask(c))) begin
                failures++;
                $display("FAIL single cyc=%0d got=%h exp=%h", c, obs_w[c] & cmp_mask(c), exp_w[c] & cmp_mask(c));
            end
        end
        // window accepted at t=1: mac_enable t+2, out_valid+out_last t+3, done t+4
        checks++;
        if (obs_w[3][25] !== 1'b1 || obs_w[4][24:23] !== 2'b11 || obs_w[5][21] !== 1'b1) begin
            failures++;
            $display("FAIL single_timing got=men%b vl%b done%b exp=1,11,1", obs_w[3][25], obs_w[4][24:23], obs_w[5][21]);
        end
        $display("pass single rows=3 cols=3 outputs=%0d", count_obs_valid(ncyc));
    endtask

    task automatic test_gapped();
        fill_stim(1, 0);
        build_model(4, 4, -1);
        drive_pass(4, 4, 0, -1);
        for (int c = 0; c < ncyc; c++) begin
            checks++;
            if ((obs_w[c] & cmp_mask(c)) !== (exp_w[c] & cmp_mask(c))) begin
                failures++;
                $display("FAIL gapped cyc=%0d got=%h exp=%h", c, obs_w[c] & cmp_mask(c), exp_w[c] & cmp_mask(c));
            end
        end
        checks++;
        if (count_obs_valid(ncyc) !== 4 || obs_w[4][25] !== 1'b0 || obs_w[5][24] !== 1'b0) begin
            failures++;
            $display("FAIL gapped_bubbles got=%0d men4=%b vl5=%b exp=4,0,0", count_obs_valid(ncyc), obs_w[4][25], obs_w[5][24]);
        end
        $display("pass gapped rows=4 cols=4 outputs=%0d", count_obs_valid(ncyc));
    endtask

    task automatic test_idle_abort();
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            abort = 1'b1; start = 1'b0; win_valid = 1'b1;
            @(negedge clk);
            checks++;
            if ({win_ready, mac_enable, out_valid, out_last, busy, done} !== 6'b0) begin
                failures++;
                $display("FAIL idle_abort cyc=%0d got=%b exp=000000", c, {win_ready, mac_enable, out_valid, out_last, busy, done});
            end
        end
        @(posedge clk); #1;
        abort = 1'b0; win_valid = 1'b0;
        $display("pass idle_abort");
    endtask

    task automatic test_cfg_err();
        fill_stim(0, 0);
        build_model(2, 8, -1);
        drive_pass(2, 8, 0, -1);
        for (int c = 0; c < ncyc; c++) begin
            checks++;
            if ((obs_w[c] & cmp_mask(c)) !== (exp_w[c] & cmp_mask(c))) begin
                failures++;
                $display("FAIL cfg_err cyc=%0d got=%h exp=%h", c, obs_w[c] & cmp_mask(c), exp_w[c] & cmp_mask(c));
            end
        end
        checks++;
        if (obs_w[1][21:20] !== 2'b11 || count_obs_valid(ncyc) !== 0) begin
            failures++;
            $display("FAIL cfg_err_flag got=done/err %b outputs %0d exp=11,0", obs_w[1][21:20], count_obs_valid(ncyc));
        end
        $display("pass cfg_err rows=2 cols=8 outputs=%0d", count_obs_valid(ncyc));
    endtask

    task automatic test_start_abort();
        fill_stim(0, 0);
        build_model(3, 4, -1);
        drive_pass(3, 4, 1, -1);
        for (int c = 0; c < ncyc; c++) begin
            checks++;
            if ((obs_w[c] & cmp_mask(c)) !== (exp_w[c] & cmp_mask(c))) begin
                failures++;
                $display("FAIL start_abort cyc=%0d got=%h exp=%h", c, obs_w[c] & cmp_mask(c), exp_w[c] & cmp_mask(c));
            end
        end
        $display("pass start_abort rows=3 cols=4 outputs=%0d", count_obs_valid(ncyc));
    endtask

    task automatic test_abort();
        fill_stim(0, 0);
        build_model(6, 6, 5);
        drive_pass(6, 6, 0, -1);
        for (int c = 0; c < ncyc; c++) begin
            checks++;
            if ((obs_w[c] & cmp_mask(c)) !== (exp_w[c] & cmp_mask(c))) begin
                failures++;
                $display("FAIL abort cyc=%0d got=%h exp=%h", c, obs_w[c] & cmp_mask(c), exp_w[c] & cmp_mask(c));
            end
        end
        // abort raised in cycle 6: no output from cycle 7 on, done in cycle 7
        checks++;
        if (obs_w[7][24] !== 1'b0 || obs_w[7][21] !== 1'b1 || count_obs_valid(ncyc) !== 3) begin
            failures++;
            $display("FAIL abort_flush got=vl%b done%b n=%0d exp=0,1,3", obs_w[7][24], obs_w[7][21], count_obs_valid(ncyc));
        end
        $display("pass abort rows=6 cols=6 outputs=%0d", count_obs_valid(ncyc));
        fill_stim(0, 0);
        build_model(6, 6, -1);
        drive_pass(6, 6, 0, -1);
        for (int c = 0; c < ncyc; c++) begin
            checks++;
            if ((obs_w[c] & cmp_mask(c)) !== (exp_w[c] & cmp_mask(c))) begin
                failures++;
                $display("FAIL after_abort cyc=%0d got=%h exp=%h", c, obs_w[c] & cmp_mask(c), exp_w[c] & cmp_mask(c));
            end
        end
        checks++;
        if (count_obs_valid(ncyc) !== 16) begin
            failures++;
            $display("FAIL after_abort_count got=%0d exp=16", count_obs_valid(ncyc));
        end
        $display("pass after_abort rows=6 cols=6 outputs=%0d", count_obs_valid(ncyc));
    endtask

    task automatic test_reset_drain();
        fill_stim(0, 0);
        build_model(5, 6, -1);
        drive_pass(5, 6, 0, 14);
        for (int c = 0; c <= 14; c++) begin
            checks++;
            if ((obs_w[c] & cmp_mask(c)) !== (exp_w[c] & cmp_mask(c))) begin
                failures++;
                $display("FAIL pre_reset cyc=%0d got=%h exp=%h", c, obs_w[c] & cmp_mask(c), exp_w[c] & cmp_mask(c));
            end
        end
        // cycle 14 is in DRAIN: busy with win_ready low
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (pack(win_ready, mac_enable, out_valid, out_last, busy, done, cfg_err, out_row, out_col) !== 27'h0) begin
            failures++;
            $display("FAIL reset_async got=%h exp=0", pack(win_ready, mac_enable, out_valid, out_last,
                     busy, done, cfg_err, out_row, out_col));
        end
        start = 1'b0; abort = 1'b0; win_valid = 1'b0;
        @(posedge clk); #2;
        rst = 1'b0;
        model_err = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if ({busy, done, out_valid, mac_enable} !== 4'b0) begin
                failures++;
                $display("FAIL reset_no_done cyc=%0d got=%b exp=0000", c, {busy, done, out_valid, mac_enable});
            end
        end
        fill_stim(0, 0);
        build_model(5, 6, -1);
        drive_pass(5, 6, 0, -1);
        for (int c = 0; c < ncyc; c++) begin
            checks++;
            if ((obs_w[c] & cmp_mask(c)) !== (exp_w[c] & cmp_mask(c))) begin
                failures++;
                $display("FAIL post_reset cyc=%0d got=%h exp=%h", c, obs_w[c] & cmp_mask(c), exp_w[c] & cmp_mask(c));
            end
        end
        $display("pass reset_drain rows=5 cols=6 outputs=%0d", count_obs_valid(ncyc));
    endtask

    task automatic test_random();
        int r;
        int cl;
        int ab;
        for (int i = 0; i < 12; i++) begin
            r  = $urandom_range(0, 8);
            cl = $urandom_range(0, 8);
            ab = -1;
            if (r >= 3 && cl >= 3 && ($urandom % 3) == 0)
                ab = $urandom_range(0, (r - 2) * (cl - 2) - 1);
            fill_stim(2, 1);
            build_model(r, cl, ab);
            drive_pass(r, cl, 0, -1);
            for (int c = 0; c < ncyc; c++) begin
                checks++;
                if ((obs_w[c] & cmp_mask(c)) !== (exp_w[c] & cmp_mask(c))) begin
                    failures++;
                    $display("FAIL random%0d cyc=%0d got=%h exp=%h", i, c, obs_w[c] & cmp_mask(c), exp_w[c] & cmp_mask(c));
                end
            end
            $display("pass random%0d rows=%0d cols=%0d abort_after=%0d outputs=%0d exp=%0d",
                     i, r, cl, ab, count_obs_valid(ncyc), exp_n_out);
        end
    endtask

    initial begin
        test_reset();
        test_full_pass();
        test_single();
        test_gapped();
        test_idle_abort();
        test_cfg_err();
        test_start_abort();
        test_abort();
        test_reset_drain();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mac_sequencer.md
MAC_SEQUENCER -- requirements
Module: mac_sequencer

Interface
REQ-001 Parameter WID_DIM, default 10: width of the feature-map dimension and position fields.
REQ-002 Parameter MAC_LAT, default 3: cycles from window presentation at the MAC inputs to the registered MAC output.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  single-cycle request to begin one feature-map pass.
REQ-006 abort  input  1  terminates the current pass.
REQ-007 cfg_rows  input  WID_DIM  input feature-map rows; sampled on an accepted start.
REQ-008 cfg_cols  input  WID_DIM  input feature-map columns; sampled on an accepted start.
REQ-009 win_valid  input  1  line buffer presents a valid 3x3 window this cycle.
REQ-010 win_ready  output  1  sequencer accepts a window this cycle.
REQ-011 mac_enable  output  1  drives the MAC enable input.
REQ-012 out_valid  output  1  MAC output is valid this cycle.
REQ-013 out_row, out_col  output  WID_DIM each  output-map position of the current out_valid.
REQ-014 out_last  output  1  marks the final output of the pass.
REQ-015 busy  output  1  pass in progress.
REQ-016 done  output  1  one-cycle pulse at the end of a pass.
REQ-017 cfg_err  output  1  sticky flag: last start had cfg_rows<3 or cfg_cols<3.

Function
REQ-018 The FSM SHALL have states IDLE, RUN, DRAIN and DONE.
REQ-019 IDLE: start with valid config SHALL latch the config, clear cfg_err, and go to RUN; busy SHALL rise on the next cycle.
REQ-020 A start with cfg_rows<3 or cfg_cols<3 SHALL set cfg_err, go to DONE, and produce zero outputs.
REQ-021 A start while busy SHALL be ignored.
REQ-022 The output map size SHALL be (cfg_rows-2) x (cfg_cols-2), using stride 1 and no padding.
REQ-023 win_ready SHALL be 1 only in RUN; a window is accepted when win_valid && win_ready.
REQ-024 Position counters SHALL run in raster order:
- col increments on each accepted window;
- col wraps to 0 at cfg_cols-3, and row then increments.
REQ-025 The window accepted at the last position (row=cfg_rows-3, col=cfg_cols-3) SHALL cause the transition RUN->DRAIN; win_ready SHALL be 0 from the next cycle.
REQ-026 For a window accepted in cycle t:
- mac_enable SHALL be 1 in cycle t+MAC_LAT-1;
- out_valid SHALL be 1 in cycle t+MAC_LAT, with that window's row/col.
REQ-027 The MAC_LAT-stage valid/position/last pipeline SHALL shift every cycle; gaps in win_valid SHALL propagate as bubbles with mac_enable=0 and out_valid=0.
REQ-028 out_last SHALL be 1 only with out_valid for the final position.
REQ-029 DRAIN SHALL go to DONE in the cycle after out_last is issued.
REQ-030 DONE SHALL assert done for one cycle, deassert busy, and return to IDLE.
REQ-031 abort in RUN or DRAIN SHALL:
- clear the valid pipeline in the same edge, so no further out_valid or mac_enable;
- go to DONE; done still pulses and out_last is not issued.
REQ-032 abort in IDLE or DONE SHALL have no effect.
REQ-033 abort and start in the same cycle in IDLE: start SHALL win.
REQ-034 Counters SHALL be WID_DIM bits wide and unsigned; a 1x1 output map (3x3 input) SHALL produce a single output with out_last=1.

Reset
REQ-035 On rst, all of the following SHALL be 0 immediately, independent of clk:
- state = IDLE, counters, valid pipeline;
- win_ready, mac_enable, out_valid, out_row, out_col, out_last, busy, done, cfg_err.
REQ-036 rst asserted mid-pass SHALL discard the pass without a done pulse.

Verification
REQ-037 start, rows=5, cols=6, win_valid held high:
- 12 outputs (3x4) in raster order (0,0)..(2,3);
- first out_valid 3 cycles after first acceptance; out_last on (2,3); done 1 cycle later.
REQ-038 rows=3, cols=3, single window accepted at cycle t:
- mac_enable at t+2; out_valid with out_last at t+3; done at t+4.
REQ-039 rows=4, cols=4, win_valid toggling 1,0,1,0:
- out_valid follows the same gapped pattern delayed 3 cycles;
- mac_enable is low in the bubble cycles; 4 outputs total.
REQ-040 rows=2, cols=8:
- cfg_err=1, done pulses, win_ready never asserts, no out_valid.
REQ-041 rows=6, cols=6, abort after 5 acceptances:
- no out_valid after the abort edge; done pulses; a new start is then accepted and a full pass of 16 outputs completes.
REQ-042 rst asserted during DRAIN:
- all outputs 0 asynchronously; no done pulse; next start runs normally.
